alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: req0 is the core datapath and req1 is the auxiliary sequencer. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin and only one operation is in flight at a time. ALU operands are registered so that the ALU input path is glitch-free, and the block keeps a wrapping count of completed operations.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, ALUOp width
CNT_W, 16, width of completed-op counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
reqN_valid  in  1  request present (N = 0,1)
reqN_ready  out  1  request accepted this cycle when valid&ready
reqN_op  in  OP_W  ALUOp code
reqN_a  in  DATA_W  operand A
reqN_b  in  DATA_W  operand B
rspN_valid  out  1  response present
rspN_ready  in  1  requester consumes response
rspN_result  out  DATA_W  ALU result
rspN_zero  out  1  ALU zero_flag
rspN_err  out  1  illegal opcode
alu_op  out  OP_W  to ALU.ALUOp
alu_a  out  DATA_W  to ALU.A
alu_b  out  DATA_W  to ALU.B
alu_result  in  DATA_W  from ALU.result
alu_zero  in  1  from ALU.zero_flag
busy  out  1  state != IDLE
ops_done  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (async, rst_n=0) sets the following, regardless of state; any in-flight op is discarded with no response:
  - state=IDLE, last_grant=1 (so req0 wins the first tie)
  - alu_op/alu_a/alu_b=0
  - all rspN_* = 0, all reqN_ready = 0
  - busy=0, ops_done=0
- Legal opcodes are 0001..1101: ADD, SUB, SHL_U, SHR_U, SHL_S, SHR_S, LT, EQ, NEQ, AND, OR, XOR, NOR. Opcodes 0000, 1110 and 1111 are illegal.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - The grant is combinational. If only one reqN_valid is high, that requester is granted. If both are high, the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & granted N. At most one ready is high in any cycle.
  - On handshake: latch the granted op/a/b into alu_op/alu_a/alu_b, latch owner=N, set last_grant=N, go to EXEC.
  - If the op is illegal, alu_op is latched as 0000, alu_a/alu_b as 0, and err_pending is set.
- EXEC (exactly 1 cycle):
  - Capture alu_result/alu_zero into the owner's rsp registers. If err_pending: result=0, zero=0, err=1.
  - Go to RESP. alu_op/a/b return to 0 on the EXEC->RESP edge.
- RESP:
  - rsp[owner]_valid=1; result/zero/err are held stable while valid & !ready.
  - When rsp[owner]_ready=1: clear valid/err, increment ops_done (wraps 2^CNT_W-1 -> 0), go to IDLE.
- Latency: handshake at edge T -> rsp valid from T+2. Minimum back-to-back issue interval is 3 cycles (when rsp_ready is already high).
- The non-owner's rsp_valid stays 0 throughout. New requests are never accepted before the response is consumed (no bypass).
- The ALU is purely combinational; the arbiter never samples alu_result outside EXEC.
- Requester inputs may change freely once not in handshake. Only values at the handshake edge matter.
- busy=1 in EXEC and RESP.

Test Plan:
- Reset release, then req0 ADD a=5 b=3 with rsp0_ready=1 -> req0_ready=1 in cycle 0; rsp0_valid at T+2 with result=0x00000008, zero=0, err=0; ops_done=1.
- Both valid from reset: req0 SUB 10,3 and req1 XOR 0xF,0x3, rsp_ready=1 -> req0 served first (result 7), then req1 (result 0x0000000C). Continuing with both valid, grants alternate 0,1,0,1.
- req1 EQ 5,5 with rsp1_ready held 0 for 5 cycles -> rsp1_valid stays high with result=1, stable for all 5 cycles. req0_valid=1 during this window sees req0_ready=0. Once rsp1_ready rises, req0 is accepted the following cycle.
- req0 op=1110, a=0xFFFFFFFF -> during EXEC, alu_op=0000 and alu_a=0. rsp0: result=0, zero=0, err=1; ops_done increments.
- SUB 3,3 -> result=0, zero=1. SHR_S 0xFFFFFFF0 by 2 -> result=0xFFFFFFFC, forwarded unchanged.
- Assert rst_n=0 in EXEC and again in RESP -> all outputs 0 immediately (async), no response delivered, ops_done=0. After release, req0 wins the first tie.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response channels of the two ALU requesters (req0 = core datapath,
// req1 = auxiliary sequencer). The arbiter connects through the slave modport.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight, registered ALU operands, wrapping completion count.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, handshake latches operands
// EXEC  | operands on the ALU for one cycle; result captured for the owner
// RESP  | owner's response valid until its rsp_ready consumes it
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ADD is the lowest legal opcode, NOR the highest
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(13);

  state_t state;
  state_t state_nxt;

  logic              last_grant;
  logic              owner;
  logic              err_pending;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              capture;
  logic              consume;

  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_legal;

  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_zero;
  logic [1:0]             rsp_err;
  logic [1:0][DATA_W-1:0] rsp_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    unique case (state)
      IDLE: begin
        // ready must stay low while reset is asserted, even with valid high
        if (rst_n) begin
          grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
          grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        end
        accept = grant0 | grant1;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        consume = owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (consume) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sel_op    = grant1 ? bus.req1_op : bus.req0_op;
  assign sel_a     = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b     = grant1 ? bus.req1_b  : bus.req0_b;
  assign sel_legal = (sel_op >= OP_ADD) && (sel_op <= OP_NOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      err_pending <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= '0;
      rsp_zero    <= '0;
      rsp_err     <= '0;
      rsp_result  <= '0;
      ops_done    <= '0;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        if (sel_legal) begin
          alu_op      <= sel_op;
          alu_a       <= sel_a;
          alu_b       <= sel_b;
          err_pending <= 1'b0;
        end else begin
          // illegal ops keep the ALU inputs quiet and report an error instead
          alu_op      <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          err_pending <= 1'b1;
        end
      end
      if (capture) begin
        rsp_valid[owner]  <= 1'b1;
        rsp_result[owner] <= err_pending ? '0   : alu_result;
        rsp_zero[owner]   <= err_pending ? 1'b0 : alu_zero;
        rsp_err[owner]    <= err_pending;
        err_pending       <= 1'b0;
        alu_op            <= '0;
        alu_a             <= '0;
        alu_b             <= '0;
      end
      if (consume) begin
        rsp_valid[owner] <= 1'b0;
        rsp_err[owner]   <= 1'b0;
        ops_done         <= ops_done + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;

  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp0_result = rsp_result[0];
  assign bus.rsp0_zero   = rsp_zero[0];
  assign bus.rsp0_err    = rsp_err[0];

  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp1_result = rsp_result[1];
  assign bus.rsp1_zero   = rsp_zero[1];
  assign bus.rsp1_err    = rsp_err[1];

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, expected responses queued at
// issue time and popped as the arbiter delivers them.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, SHR_S = 4'd6, LT = 4'd7,
                         EQ = 4'd8, AND_ = 4'd10, OR_ = 4'd11, XOR_ = 4'd12, NOR_ = 4'd13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_zero, busy;
  logic [CNT_W-1:0]  ops_done;

  int checks = 0, failures = 0, cyc = 0, hs_cyc = 0, exp_ops = 0, waited = 0;

  typedef struct {
    bit          id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;
  exp_t sb[$];

  alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus();

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd1:  alu_result = alu_a + alu_b;
      4'd2:  alu_result = alu_a - alu_b;
      4'd3:  alu_result = alu_a << alu_b[4:0];
      4'd4:  alu_result = alu_a >> alu_b[4:0];
      4'd5:  alu_result = alu_a <<< alu_b[4:0];
      4'd6:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd7:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd8:  alu_result = {31'b0, alu_a == alu_b};
      4'd9:  alu_result = {31'b0, alu_a != alu_b};
      4'd10: alu_result = alu_a & alu_b;
      4'd11: alu_result = alu_a | alu_b;
      4'd12: alu_result = alu_a ^ alu_b;
      4'd13: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    chk("ready_onehot", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
    chk("rsp_valid_onehot", {31'b0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic push(input bit id, input logic [31:0] res, input logic zero, input logic err);
    exp_t e;
    e.id = id; e.res = res; e.zero = zero; e.err = err;
    sb.push_back(e);
  endtask

  // returns at the handshake cycle, before the accepting edge
  task automatic await_accept(input bit id);
    int n = 0;
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk(id ? "accept1_timeout" : "accept0_timeout", {31'b0, n < 20}, 32'd1);
    waited = n;
    hs_cyc = cyc;
  endtask

  // returns in the first cycle the expected requester's response is valid
  task automatic await_rsp(input bit chk_lat);
    exp_t e;
    int n = 0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    #1;
    while (!(e.id ? bus.rsp1_valid : bus.rsp0_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(e.id ? "rsp1_timeout" : "rsp0_timeout", {31'b0, n < 20}, 32'd1);
    chk("rsp_other_valid", {31'b0, e.id ? bus.rsp0_valid : bus.rsp1_valid}, 32'd0);
    chk("rsp_result", e.id ? bus.rsp1_result : bus.rsp0_result, e.res);
    chk("rsp_zero", {31'b0, e.id ? bus.rsp1_zero : bus.rsp0_zero}, {31'b0, e.zero});
    chk("rsp_err", {31'b0, e.id ? bus.rsp1_err : bus.rsp0_err}, {31'b0, e.err});
    if (chk_lat) chk("rsp_latency", cyc - hs_cyc, 32'd2);
  endtask

  task automatic consume();
    tick();
    exp_ops++;
    chk("ops_done", {16'b0, ops_done}, exp_ops);
  endtask

  task automatic run_one(input bit id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic zero, input logic err);
    set_req(id, 1'b1, op, a, b);
    push(id, res, zero, err);
    await_accept(id);
    tick();
    set_req(id, 1'b0, 4'd0, 32'd0, 32'd0);
    await_rsp(1'b1);
    consume();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    exp_ops = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, ADD, 32'd1, 32'd1);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ops_done", {16'b0, ops_done}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single ADD from req0
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set_req(0, 1'b1, ADD, 32'd5, 32'd3);
    push(0, 32'h8, 1'b0, 1'b0);
    await_accept(0);
    chk("add_ready_cycle0", waited, 32'd0);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("exec_alu_op", {28'b0, alu_op}, {28'b0, ADD});
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd3);
    chk("exec_busy", {31'b0, busy}, 32'd1);
    await_rsp(1'b1);
    chk("resp_alu_op_cleared", {28'b0, alu_op}, 32'd0);
    chk("resp_busy", {31'b0, busy}, 32'd1);
    consume();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);

    // both valid from reset: 0,1,0,1
    do_reset();
    set_req(0, 1'b1, SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, XOR_, 32'hF, 32'h3);
    push(0, 32'd7, 1'b0, 1'b0);
    push(1, 32'hC, 1'b0, 1'b0);
    push(0, 32'd7, 1'b0, 1'b0);
    push(1, 32'hC, 1'b0, 1'b0);
    await_accept(0);
    chk("tie_req0_first", waited, 32'd0);
    chk("tie_req1_not_ready", {31'b0, bus.req1_ready}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      await_rsp(i == 0);
      if (i == 3) begin
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      end
      consume();
    end

    // req1 response back-pressured for 5 cycles while req0 waits
    bus.rsp1_ready = 1'b0;
    set_req(1, 1'b1, EQ, 32'd5, 32'd5);
    push(1, 32'd1, 1'b0, 1'b0);
    await_accept(1);
    tick();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(0, 1'b1, ADD, 32'd1, 32'd1);
    await_rsp(1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
      chk("hold_rsp1_result", bus.rsp1_result, 32'd1);
      chk("hold_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    consume();
    push(0, 32'd2, 1'b0, 1'b0);
    await_accept(0);
    chk("after_release_req0_ready", waited, 32'd0);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    await_rsp(1'b1);
    consume();

    // illegal opcode 1110
    set_req(0, 1'b1, 4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(0, 32'd0, 1'b0, 1'b1);
    await_accept(0);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("illegal_alu_op", {28'b0, alu_op}, 32'd0);
    chk("illegal_alu_a", alu_a, 32'd0);
    chk("illegal_alu_b", alu_b, 32'd0);
    await_rsp(1'b1);
    consume();

    // result forwarding and opcode boundaries
    run_one(0, SUB,   32'd3,          32'd3,         32'd0,          1'b1, 1'b0);
    run_one(0, SHR_S, 32'hFFFF_FFF0,  32'd2,         32'hFFFF_FFFC,  1'b0, 1'b0);
    run_one(1, LT,    32'hFFFF_FFFF,  32'd1,         32'd1,          1'b0, 1'b0);
    run_one(1, NOR_,  32'd0,          32'd0,         32'hFFFF_FFFF,  1'b0, 1'b0);
    run_one(1, AND_,  32'hF0F0_0000,  32'h0F0F_FFFF, 32'd0,          1'b1, 1'b0);
    run_one(0, 4'h0,  32'd4,          32'd4,         32'd0,          1'b0, 1'b1);
    run_one(1, 4'hF,  32'd4,          32'd4,         32'd0,          1'b0, 1'b1);

    // reset during EXEC
    set_req(0, 1'b1, ADD, 32'd7, 32'd7);
    await_accept(0);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("pre_rst_exec_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_busy", {31'b0, busy}, 32'd0);
    chk("rst_exec_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_exec_alu_a", alu_a, 32'd0);
    chk("rst_exec_ops_done", {16'b0, ops_done}, 32'd0);
    exp_ops = 0;
    tick();
    chk("rst_exec_no_rsp", {31'b0, bus.rsp0_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // reset during RESP, then a tie that req0 must win
    bus.rsp0_ready = 1'b0;
    set_req(0, 1'b1, OR_, 32'hF0, 32'h0F);
    await_accept(0);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("pre_rst_resp_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("rst_resp_result", bus.rsp0_result, 32'd0);
    chk("rst_resp_busy", {31'b0, busy}, 32'd0);
    chk("rst_resp_ops_done", {16'b0, ops_done}, 32'd0);
    bus.rsp0_ready = 1'b1;
    set_req(0, 1'b1, ADD, 32'd2, 32'd2);
    set_req(1, 1'b1, SUB, 32'd9, 32'd4);
    #1;
    chk("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_tie_req0", {31'b0, bus.req0_ready}, 32'd1);
    chk("post_rst_tie_req1", {31'b0, bus.req1_ready}, 32'd0);
    push(0, 32'd4, 1'b0, 1'b0);
    push(1, 32'd5, 1'b0, 1'b0);
    hs_cyc = cyc;
    tick();
    await_rsp(1'b1);
    consume();
    await_rsp(1'b0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    consume();
    tick();
    chk("final_idle_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
